// File: rtl/avg_pool.sv
// Streaming average pool: sums POOL_SIZE signed samples per window and emits sum >>> log2(POOL_SIZE).
// Optional macro AVG_POOL_ROUND_EN adds round-half-up before the shift; default is floor.
module avg_pool #(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  POOL_SIZE  = 8,
    localparam int unsigned SHIFT      = $clog2(POOL_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_sample,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SHIFT-1:0]             win_cnt
);

    localparam int unsigned ACC_W = DATA_WIDTH + SHIFT + 1;

    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [SHIFT-1:0]             win_cnt_q, win_cnt_d;
    logic signed [DATA_WIDTH-1:0] out_sample_q, out_sample_d;
    logic                         out_valid_q, out_valid_d;

    logic                         in_xfer;
    logic                         out_xfer;
    logic                         win_done;
    logic signed [ACC_W-1:0]      in_ext;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      sum_adj;
    logic signed [ACC_W-1:0]      shifted;
    logic                         unused_shift_bits;

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign win_done = (win_cnt_q == SHIFT'(POOL_SIZE - 1));

    assign in_ext = {{(SHIFT + 1){in_sample[DATA_WIDTH-1]}}, in_sample};
    assign sum    = acc_q + in_ext;

`ifdef AVG_POOL_ROUND_EN
    // Half an LSB of the result, giving round-half-toward-+inf after the shift.
    localparam logic signed [ACC_W-1:0] RoundBias = ACC_W'(1) << (SHIFT - 1);
    assign sum_adj = sum + RoundBias;
`else
    assign sum_adj = sum;
`endif

    assign shifted = sum_adj >>> SHIFT;
    // The window sum divided by POOL_SIZE always fits DATA_WIDTH, so the upper bits are redundant.
    assign unused_shift_bits = ^shifted[ACC_W-1:DATA_WIDTH];

    always_comb begin
        acc_d        = acc_q;
        win_cnt_d    = win_cnt_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            if (win_done) begin
                out_sample_d = shifted[DATA_WIDTH-1:0];
                out_valid_d  = 1'b1;
                acc_d        = '0;
                win_cnt_d    = '0;
            end else begin
                acc_d     = sum;
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            win_cnt_q    <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            win_cnt_q    <= win_cnt_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign win_cnt    = win_cnt_q;

endmodule

// File: doc/avg_pool.md
AVG_POOL -- requirements
Module: avg_pool

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the signed sample width of input and output.
REQ-002 Parameter POOL_SIZE, default 8, SHALL set the number of input samples averaged per output; legal values are powers of two, 2..256.
REQ-003 Derived constant SHIFT = log2(POOL_SIZE) and accumulator width ACC_W = DATA_WIDTH + SHIFT + 1 SHALL be computed internally, not exposed as parameters.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 in_sample  input  DATA_WIDTH (signed)  SHALL be the streaming sample, e.g. the scaled conv output.
REQ-007 in_valid  input  1  SHALL qualify in_sample.
REQ-008 in_ready  output  1  SHALL indicate the block accepts in_sample this cycle.
REQ-009 out_sample  output  DATA_WIDTH (signed)  SHALL be the pooled average.
REQ-010 out_valid  output  1  SHALL qualify out_sample.
REQ-011 out_ready  input  1  SHALL indicate the downstream consumer accepts out_sample this cycle.
REQ-012 win_cnt  output  SHIFT  SHALL report the number of samples accumulated in the current, incomplete window.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready; it is combinational and does not depend on in_valid.
REQ-015 Each input transfer SHALL sign-extend in_sample into the ACC_W accumulator and increment win_cnt.
REQ-016 The transfer that completes a window (win_cnt == POOL_SIZE-1) SHALL register out_sample = (acc + in_sample) arithmetically shifted right by SHIFT, set out_valid, clear acc and reset win_cnt to 0, all in the same edge.
REQ-017 Latency SHALL be 1 cycle: out_valid rises on the edge following the window-completing input transfer.
REQ-018 Windows SHALL be non-overlapping (stride = POOL_SIZE); no sample SHALL be dropped or counted twice.
REQ-019 While out_valid && !out_ready, out_sample and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-020 An output transfer without a simultaneous window completion SHALL clear out_valid on the next edge.
REQ-021 Simultaneous output transfer and window-completing input transfer SHALL load the new result and keep out_valid high (back-to-back, no bubble).
REQ-022 The shifted result always fits DATA_WIDTH; no saturation SHALL be applied.
REQ-023 Idle cycles (in_valid low) SHALL leave acc and win_cnt unchanged; windows MAY span arbitrary gaps.

Reset
REQ-024 While rst is high at a clock edge: acc = 0, win_cnt = 0, out_sample = 0, out_valid = 0; in_ready is consequently 1.
REQ-025 Reset asserted mid-window or during a stalled output SHALL discard the partial window and the pending result; the first accepted sample after reset starts a new window.

Configuration
REQ-026 Macro AVG_POOL_ROUND_EN defined: the block SHALL add 2^(SHIFT-1) to the sum before the arithmetic shift (round half toward +infinity).
REQ-027 AVG_POOL_ROUND_EN undefined: the block SHALL apply the plain arithmetic shift (floor toward -infinity); no rounding adder is synthesised.

Verification (POOL_SIZE=4, DATA_WIDTH=16 unless stated)
REQ-028 Inputs 1,2,3,4 with out_ready=1 -> out_sample=2 (no macro) or 3 (AVG_POOL_ROUND_EN), out_valid high exactly one cycle, one cycle after sample 4.
REQ-029 Inputs -1,-2,-3,-4 -> out_sample=-3 (no macro) or -2 (AVG_POOL_ROUND_EN).
REQ-030 Extremes: four samples of 32767 -> 32767; four of -32768 -> -32768; no wrap.
REQ-031 Backpressure: out_ready=0 for 5 cycles after result 2 -> out_sample held at 2, in_ready=0 throughout; out_ready=1 then releases and input resumes.
REQ-032 Continuous in_valid=1, out_ready=1, inputs 1..8 -> results 2 then 6 (no macro) with no bubble and in_ready constantly 1.
REQ-033 Reset after inputs 7,7 (win_cnt=2) -> win_cnt=0, out_valid=0; next inputs 4,4,4,4 -> out_sample=4.
